// File: rtl/vmac_pkg.sv
// Shared types and constants for the vector MAC transmit path.
// Beat layout is 16 byte lanes on a fixed 128-bit bus; lane i sits at bits [8i+7:8i].
package vmac_pkg;

    localparam int BUSW       = 128;
    localparam int BYTE_W     = 8;
    localparam int LANE_MAX   = 16;
    localparam int LANE_IDX_W = $clog2(LANE_MAX);

    typedef logic [LANE_MAX-1:0][BYTE_W-1:0] beat_t;

    typedef enum logic {
        FILL = 1'b0,
        GAP  = 1'b1
    } pack_state_e;

    function automatic int beats_per_vec(input int elems, input int lanes);
        return (elems + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/lane_stager.sv
// Byte-addressed A/B staging register; cur_a/cur_b show staged bytes merged with this cycle's write.
// Latency: write visible combinationally on cur_*, registered next edge. No backpressure; clr wins over write.
module lane_stager
    import vmac_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LANE_IDX_W-1:0] wr_lane,
    input  logic [BYTE_W-1:0]     wr_a,
    input  logic [BYTE_W-1:0]     wr_b,
    input  logic                  clr,
    output beat_t                 cur_a,
    output beat_t                 cur_b
);

    beat_t stage_a;
    beat_t stage_b;

    // Merged view lets the closing byte land in the outgoing beat without an extra cycle.
    always_comb begin
        cur_a = stage_a;
        cur_b = stage_b;
        if (wr_en) begin
            cur_a[wr_lane] = wr_a;
            cur_b[wr_lane] = wr_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_a <= '0;
            stage_b <= '0;
        end else if (clr) begin
            stage_a <= '0;
            stage_b <= '0;
        end else if (wr_en) begin
            stage_a[wr_lane] <= wr_a;
            stage_b[wr_lane] <= wr_b;
        end
    end

endmodule

// File: rtl/vec_beat_packer.sv
// Packs INT8 operand pairs into ACTIVE_LANES-wide beats framed as ELEMS-element vectors for the MAC.
// Latency: 1 cycle from the closing acceptance to vec_valid. Backpressure: in_ready low for the one GAP cycle after each vector.
module vec_beat_packer
    import vmac_pkg::*;
#(
    parameter int ELEMS        = 1000,
    parameter int ACTIVE_LANES = 8
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_a,
    input  logic [7:0]      in_b,
    input  logic            abort,
    output logic            vec_valid,
    output logic [BUSW-1:0] vec_a,
    output logic [BUSW-1:0] vec_b,
    output logic            vec_done,
    output logic [15:0]     vec_count
);

    localparam int CNT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CNT_W-1:0]      LAST_ELEM = CNT_W'(ELEMS - 1);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(ACTIVE_LANES - 1);

    pack_state_e state;
    pack_state_e state_nxt;

    logic [LANE_IDX_W-1:0] lane_idx;
    logic [CNT_W-1:0]      elem_cnt;

    logic  accept;
    logic  vec_last;
    logic  beat_close;
    beat_t cur_a;
    beat_t cur_b;

    // Ready depends on state alone; held low while reset is asserted.
    assign in_ready   = rst_n && (state == FILL);
    assign accept     = in_valid && in_ready && !abort;
    assign vec_last   = accept && (elem_cnt == LAST_ELEM);
    assign beat_close = accept && ((lane_idx == LAST_LANE) || (elem_cnt == LAST_ELEM));

    lane_stager u_stager (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_lane (lane_idx),
        .wr_a    (in_a),
        .wr_b    (in_b),
        .clr     (beat_close || abort),
        .cur_a   (cur_a),
        .cur_b   (cur_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (vec_last) state_nxt = GAP;
            GAP:     state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
        if (abort) begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_idx <= '0;
            elem_cnt <= '0;
        end else if (abort) begin
            lane_idx <= '0;
            elem_cnt <= '0;
        end else if (accept) begin
            lane_idx <= beat_close ? '0 : lane_idx + LANE_IDX_W'(1);
            elem_cnt <= vec_last   ? '0 : elem_cnt + CNT_W'(1);
        end
    end

    // Bus is driven to zero on every non-beat cycle so idle data never carries stale bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_valid <= 1'b0;
            vec_a     <= '0;
            vec_b     <= '0;
            vec_done  <= 1'b0;
            vec_count <= '0;
        end else begin
            vec_valid <= beat_close;
            vec_a     <= beat_close ? cur_a : '0;
            vec_b     <= beat_close ? cur_b : '0;
            vec_done  <= vec_last;
            if (vec_last) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vec_beat_packer.sv
// Directed bench for vec_beat_packer with three lane configurations sharing one clock and reset.
module tb_vec_beat_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   stuck  = 0;

    localparam logic [127:0] ONES8   = 128'h0000_0000_0000_0000_0101_0101_0101_0101;
    localparam logic [127:0] TWOS8   = 128'h0000_0000_0000_0000_0202_0202_0202_0202;
    localparam logic [127:0] THREES8 = 128'h0000_0000_0000_0000_0303_0303_0303_0303;
    localparam logic [127:0] FF_HALF = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;

    logic a8_in_valid, a8_in_ready, a8_abort, a8_vec_valid, a8_vec_done;
    logic [7:0] a8_in_a, a8_in_b;
    logic [127:0] a8_vec_a, a8_vec_b;
    logic [15:0] a8_vec_count;

    logic a16_in_valid, a16_in_ready, a16_abort, a16_vec_valid, a16_vec_done;
    logic [7:0] a16_in_a, a16_in_b;
    logic [127:0] a16_vec_a, a16_vec_b;
    logic [15:0] a16_vec_count;

    logic a1_in_valid, a1_in_ready, a1_abort, a1_vec_valid, a1_vec_done;
    logic [7:0] a1_in_a, a1_in_b;
    logic [127:0] a1_vec_a, a1_vec_b;
    logic [15:0] a1_vec_count;

    vec_beat_packer #(.ELEMS(1000), .ACTIVE_LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .in_valid(a8_in_valid), .in_ready(a8_in_ready),
        .in_a(a8_in_a), .in_b(a8_in_b), .abort(a8_abort), .vec_valid(a8_vec_valid),
        .vec_a(a8_vec_a), .vec_b(a8_vec_b), .vec_done(a8_vec_done), .vec_count(a8_vec_count)
    );

    vec_beat_packer #(.ELEMS(1000), .ACTIVE_LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(a16_in_valid), .in_ready(a16_in_ready),
        .in_a(a16_in_a), .in_b(a16_in_b), .abort(a16_abort), .vec_valid(a16_vec_valid),
        .vec_a(a16_vec_a), .vec_b(a16_vec_b), .vec_done(a16_vec_done), .vec_count(a16_vec_count)
    );

    vec_beat_packer #(.ELEMS(1000), .ACTIVE_LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(a1_in_valid), .in_ready(a1_in_ready),
        .in_a(a1_in_a), .in_b(a1_in_b), .abort(a1_abort), .vec_valid(a1_vec_valid),
        .vec_a(a1_vec_a), .vec_b(a1_vec_b), .vec_done(a1_vec_done), .vec_count(a1_vec_count)
    );

    function automatic longint dot(input logic [127:0] a, input logic [127:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < 16; i++) s += longint'(a[8*i +: 8]) * longint'(b[8*i +: 8]);
        return s;
    endfunction

    // MAC stand-in: accumulates beats and flags bus activity that should never occur.
    longint m8_sum = 0, m16_sum = 0;
    int m8_beats = 0, m8_dones = 0, m8_viol = 0, m8_hi = 0;
    int m16_beats = 0, m16_dones = 0, m16_viol = 0;
    int m1_beats = 0, m1_viol = 0, m1_hi = 0;
    logic [127:0] m16_last_a = '0, m16_last_b = '0;

    always @(negedge clk) begin
        if (a8_vec_valid) begin
            m8_beats++;
            m8_sum += dot(a8_vec_a, a8_vec_b);
            if (a8_vec_a[127:64] != 0 || a8_vec_b[127:64] != 0) m8_hi++;
        end else if (a8_vec_a != 0 || a8_vec_b != 0 || a8_vec_done) m8_viol++;
        if (a8_vec_done) m8_dones++;

        if (a16_vec_valid) begin
            m16_beats++;
            m16_sum += dot(a16_vec_a, a16_vec_b);
            m16_last_a = a16_vec_a;
            m16_last_b = a16_vec_b;
        end else if (a16_vec_a != 0 || a16_vec_b != 0 || a16_vec_done) m16_viol++;
        if (a16_vec_done) m16_dones++;

        if (a1_vec_valid) begin
            m1_beats++;
            if (a1_vec_a[127:8] != 0 || a1_vec_b[127:8] != 0) m1_hi++;
        end else if (a1_vec_a != 0 || a1_vec_b != 0 || a1_vec_done) m1_viol++;
    end

    task automatic push8(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        a8_in_valid = 1'b1; a8_in_a = a; a8_in_b = b;
        while (!a8_in_ready && t < 8) begin @(posedge clk); #1; t++; end
        if (!a8_in_ready) stuck++;
        @(posedge clk); #1;
        a8_in_valid = 1'b0;
    endtask

    task automatic push16(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        a16_in_valid = 1'b1; a16_in_a = a; a16_in_b = b;
        while (!a16_in_ready && t < 8) begin @(posedge clk); #1; t++; end
        if (!a16_in_ready) stuck++;
        @(posedge clk); #1;
        a16_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a8_in_valid = 1'b1; a8_in_a = 8'h5A; a8_in_b = 8'hA5; a8_abort = 1'b0;
        a16_in_valid = 1'b0; a16_in_a = '0; a16_in_b = '0; a16_abort = 1'b0;
        a1_in_valid = 1'b0; a1_in_a = '0; a1_in_b = '0; a1_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a8_vec_valid !== 1'b0) begin errors++; $display("FAIL rst_vec_valid got %0b want 0", a8_vec_valid); end
        checks++; if (a8_vec_a !== '0 || a8_vec_b !== '0) begin errors++; $display("FAIL rst_vec_data got %h/%h want 0", a8_vec_a, a8_vec_b); end
        checks++; if (a8_vec_done !== 1'b0) begin errors++; $display("FAIL rst_vec_done got %0b want 0", a8_vec_done); end
        checks++; if (a8_vec_count !== 16'd0) begin errors++; $display("FAIL rst_vec_count got %0d want 0", a8_vec_count); end
        checks++; if (a8_in_ready !== 1'b0 || a16_in_ready !== 1'b0 || a1_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b%0b%0b want 000", a8_in_ready, a16_in_ready, a1_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        a8_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (a8_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", a8_in_ready); end
    endtask

    task automatic test_ones_l8;
        longint s0;
        int b0, d0, bad;
        s0 = m8_sum; b0 = m8_beats; d0 = m8_dones; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            push8(8'd1, 8'd1);
            if (i == 6) begin
                checks++; if (a8_vec_valid !== 1'b0) begin errors++; $display("FAIL early_beat got %0b want 0", a8_vec_valid); end
            end
            if (i == 7) begin
                checks++; if (a8_vec_valid !== 1'b1 || a8_vec_a !== ONES8) begin errors++; $display("FAIL first_beat got v=%0b a=%h want v=1 a=%h", a8_vec_valid, a8_vec_a, ONES8); end
            end
            if (a8_vec_valid && (a8_vec_a !== ONES8 || a8_vec_b !== ONES8)) bad++;
        end
        checks++; if (a8_vec_valid !== 1'b1 || a8_vec_done !== 1'b1) begin errors++; $display("FAIL final_beat_done got v=%0b d=%0b want 1/1", a8_vec_valid, a8_vec_done); end
        checks++; if (a8_in_ready !== 1'b0) begin errors++; $display("FAIL gap_in_ready got %0b want 0", a8_in_ready); end
        checks++; if (a8_vec_count !== 16'd1) begin errors++; $display("FAIL ones_count got %0d want 1", a8_vec_count); end
        @(posedge clk); #1;
        checks++; if (a8_vec_valid !== 1'b0 || a8_in_ready !== 1'b1) begin errors++; $display("FAIL idle_sep got v=%0b r=%0b want 0/1", a8_vec_valid, a8_in_ready); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ones_beat_data got %0d bad want 0", bad); end
        checks++; if (m8_beats - b0 !== 125) begin errors++; $display("FAIL ones_beats got %0d want 125", m8_beats - b0); end
        checks++; if (m8_sum - s0 !== 64'd1000) begin errors++; $display("FAIL ones_sum got %0d want 1000", m8_sum - s0); end
        checks++; if (m8_dones - d0 !== 1) begin errors++; $display("FAIL ones_dones got %0d want 1", m8_dones - d0); end
    endtask

    task automatic test_ff_l16;
        longint s0;
        int b0, d0;
        s0 = m16_sum; b0 = m16_beats; d0 = m16_dones;
        for (int i = 0; i < 1000; i++) push16(8'hFF, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (m16_beats - b0 !== 63) begin errors++; $display("FAIL l16_beats got %0d want 63", m16_beats - b0); end
        checks++; if (m16_sum - s0 !== 64'd65025000) begin errors++; $display("FAIL l16_sum got %0d want 65025000", m16_sum - s0); end
        checks++; if (m16_last_a !== FF_HALF || m16_last_b !== FF_HALF) begin errors++; $display("FAIL l16_pad_beat got %h/%h want %h", m16_last_a, m16_last_b, FF_HALF); end
        checks++; if (m16_dones - d0 !== 1 || a16_vec_count !== 16'd1) begin errors++; $display("FAIL l16_done got %0d/%0d want 1/1", m16_dones - d0, a16_vec_count); end
        checks++; if (m16_viol !== 0) begin errors++; $display("FAIL l16_idle_bus got %0d want 0", m16_viol); end
    endtask

    task automatic test_l1_back_to_back;
        int k, cyc, rdy_low, idle, bad, b0;
        logic acc;
        logic [7:0] sent;
        k = 0; cyc = 0; rdy_low = 0; idle = 0; bad = 0; b0 = m1_beats;
        a1_in_valid = 1'b1; a1_in_a = 8'd0; a1_in_b = 8'd2;
        while (k < 2000 && cyc < 2200) begin
            acc = a1_in_ready;
            sent = a1_in_a;
            if (acc) k++; else rdy_low++;
            @(posedge clk); #1;
            cyc++;
            a1_in_a = 8'(k);
            if (acc) begin
                if (a1_vec_valid !== 1'b1 || a1_vec_a !== {120'd0, sent} || a1_vec_b !== {120'd0, 8'd2}) bad++;
            end else if (a1_vec_valid !== 1'b0) bad++;
            if (!a1_vec_valid) idle++;
        end
        checks++; if (k !== 2000) begin errors++; $display("FAIL l1_accepts got %0d want 2000", k); end
        checks++; if (a1_vec_done !== 1'b1 || a1_vec_count !== 16'd2) begin errors++; $display("FAIL l1_done got d=%0b cnt=%0d want 1/2", a1_vec_done, a1_vec_count); end
        checks++; if (a1_in_ready !== 1'b0) begin errors++; $display("FAIL l1_gap_ready got %0b want 0", a1_in_ready); end
        a1_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy_low !== 1) begin errors++; $display("FAIL l1_ready_low got %0d want 1", rdy_low); end
        checks++; if (idle !== 1) begin errors++; $display("FAIL l1_idle_cycles got %0d want 1", idle); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL l1_beat_data got %0d bad want 0", bad); end
        checks++; if (m1_beats - b0 !== 2000 || m1_hi !== 0) begin errors++; $display("FAIL l1_beats got %0d hi=%0d want 2000 hi=0", m1_beats - b0, m1_hi); end
    endtask

    task automatic test_abort;
        longint s0;
        int b0, d0;
        for (int i = 0; i < 500; i++) push8(8'd9, 8'd9);
        a8_in_valid = 1'b1; a8_in_a = 8'd9; a8_in_b = 8'd9; a8_abort = 1'b1;
        checks++; if (a8_in_ready !== 1'b1) begin errors++; $display("FAIL abort_handshake_ready got %0b want 1", a8_in_ready); end
        @(posedge clk); #1;
        a8_abort = 1'b0; a8_in_valid = 1'b0;
        checks++; if (a8_vec_valid !== 1'b0 || a8_vec_done !== 1'b0 || a8_vec_count !== 16'd1) begin errors++; $display("FAIL abort_no_beat got v=%0b d=%0b cnt=%0d want 0/0/1", a8_vec_valid, a8_vec_done, a8_vec_count); end
        s0 = m8_sum; b0 = m8_beats; d0 = m8_dones;
        for (int i = 0; i < 1000; i++) begin
            push8(8'd2, 8'd3);
            if (i == 7) begin
                checks++; if (a8_vec_a !== TWOS8 || a8_vec_b !== THREES8) begin errors++; $display("FAIL abort_first_beat got %h/%h want %h/%h", a8_vec_a, a8_vec_b, TWOS8, THREES8); end
            end
        end
        @(posedge clk); #1;
        checks++; if (m8_sum - s0 !== 64'd6000) begin errors++; $display("FAIL abort_sum got %0d want 6000", m8_sum - s0); end
        checks++; if (m8_beats - b0 !== 125 || m8_dones - d0 !== 1) begin errors++; $display("FAIL abort_framing got beats=%0d dones=%0d want 125/1", m8_beats - b0, m8_dones - d0); end
        checks++; if (a8_vec_count !== 16'd2) begin errors++; $display("FAIL abort_count got %0d want 2", a8_vec_count); end
    endtask

    task automatic test_mid_reset;
        longint s0;
        int b0;
        for (int i = 0; i < 296; i++) push8(8'd1, 8'd1);
        checks++; if (a8_vec_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_beat got %0b want 1", a8_vec_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a8_vec_valid !== 1'b0 || a8_vec_a !== '0 || a8_vec_b !== '0) begin errors++; $display("FAIL async_reset_out got v=%0b a=%h want 0", a8_vec_valid, a8_vec_a); end
        checks++; if (a8_vec_count !== 16'd0 || a1_vec_count !== 16'd0 || a16_vec_count !== 16'd0) begin errors++; $display("FAIL async_reset_count got %0d/%0d/%0d want 0", a8_vec_count, a1_vec_count, a16_vec_count); end
        checks++; if (a8_in_ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready got %0b want 0", a8_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s0 = m8_sum; b0 = m8_beats;
        for (int i = 0; i < 1000; i++) push8(8'd1, 8'd1);
        @(posedge clk); #1;
        checks++; if (a8_vec_count !== 16'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", a8_vec_count); end
        checks++; if (m8_sum - s0 !== 64'd1000 || m8_beats - b0 !== 125) begin errors++; $display("FAIL post_reset_vec got sum=%0d beats=%0d want 1000/125", m8_sum - s0, m8_beats - b0); end
    endtask

    task automatic test_stall;
        longint s0, gold;
        int b0, d0;
        logic [7:0] pa, pb;
        s0 = m8_sum; b0 = m8_beats; d0 = m8_dones; gold = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 3 == 1) begin
                a8_in_valid = 1'b0; a8_in_a = 8'hEE; a8_in_b = 8'hEE;
                @(posedge clk); #1;
            end
            pa = 8'(i * 7 + 3);
            pb = 8'(i * 13 + 1);
            gold += longint'(pa) * longint'(pb);
            push8(pa, pb);
        end
        @(posedge clk); #1;
        checks++; if (m8_sum - s0 !== gold) begin errors++; $display("FAIL stall_sum got %0d want %0d", m8_sum - s0, gold); end
        checks++; if (m8_beats - b0 !== 125 || m8_dones - d0 !== 1) begin errors++; $display("FAIL stall_framing got beats=%0d dones=%0d want 125/1", m8_beats - b0, m8_dones - d0); end
        checks++; if (a8_vec_count !== 16'd2) begin errors++; $display("FAIL stall_count got %0d want 2", a8_vec_count); end
        checks++; if (m8_hi !== 0 || m8_viol !== 0 || m1_viol !== 0) begin errors++; $display("FAIL bus_hygiene got hi=%0d idle8=%0d idle1=%0d want 0", m8_hi, m8_viol, m1_viol); end
        checks++; if (stuck !== 0) begin errors++; $display("FAIL ready_timeout got %0d want 0", stuck); end
    endtask

    initial begin
        test_reset();
        test_ones_l8();
        test_ff_l16();
        test_l1_back_to_back();
        test_abort();
        test_mid_reset();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_beat_packer.md
Name: vec_beat_packer

Overview:
- Transmit-side front end for vector_mac_top_param.
- Accepts a stream of INT8 operand pairs, one pair per cycle under a valid/ready handshake.
- Packs them into ACTIVE_LANES-wide 128-bit beats and drives vec_valid/vec_a/vec_b with correct vector framing: ELEMS elements per vector, zero-padded final beat, mandatory idle cycle between vectors.
- Sits between the operand buffers and the MAC; its output ports connect 1:1 to the MAC input ports.

Parameters:
- ELEMS, 1000, elements per vector (>=1).
- ACTIVE_LANES, 8, INT8 lanes per beat; legal values 1, 4, 8, 16.
- BUSW, 128, output bus width; fixed at 16 x 8 bits.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  packer can accept a pair this cycle.
- in_a  in  8  operand A byte, unsigned.
- in_b  in  8  operand B byte, unsigned.
- abort  in  1  synchronous; discards the partial vector.
- vec_valid  out  1  beat valid to MAC.
- vec_a  out  BUSW  packed A beat; lane i = bits [8i+7:8i].
- vec_b  out  BUSW  packed B beat.
- vec_done  out  1  one-cycle pulse coincident with the final beat of each vector.
- vec_count  out  16  completed vectors since reset; wraps at 65535->0.

Behaviour:
- Reset (async assert, sync release): vec_valid=0, vec_a=0, vec_b=0, vec_done=0, vec_count=0, in_ready=0 while rst_n low; internal lane_idx=0, elem_cnt=0, staging=0, state=FILL.
- Handshake: a pair is accepted on a cycle with in_valid&&in_ready. in_ready is combinational from state only: 1 in FILL, 0 in GAP and during reset.
- Staging: an accepted pair is written to staging byte lane_idx of A and B. Then lane_idx++ and elem_cnt++.
- Beat close: the beat closes on acceptance when lane_idx==ACTIVE_LANES-1 or elem_cnt==ELEMS-1.
  - On the next cycle, vec_valid=1, vec_a/vec_b = staged beat including the just-accepted byte. Latency is 1 cycle from closing acceptance to beat.
  - Staging clears to 0 and lane_idx resets to 0 in the same edge.
- Output hold: vec_valid is high for exactly one cycle per beat. vec_a/vec_b return to 0 whenever vec_valid=0.
- Byte masking: bytes >= ACTIVE_LANES are always 0. Unfilled lanes of the final beat are 0. Lane masking of stale data is not permitted.
- Input stalls: mid-vector gaps in in_valid produce gaps in vec_valid. The MAC counts beats qualified by vec_valid, so gaps are legal.
- Beats per vector: ceil(ELEMS/ACTIVE_LANES).
- Vector end: the final beat carries vec_done=1. vec_count increments on the same edge that raises vec_done. elem_cnt resets to 0.
  - FSM enters GAP: in_ready=0 for exactly one cycle, during which the final beat is on the bus.
  - The following cycle vec_valid is guaranteed 0 (the idle separator), then FILL resumes. The earliest next-vector acceptance is that cycle, so the next beat is no earlier than 2 cycles after the final beat.
- FSM: FILL -(final element accepted)-> GAP -(1 cycle)-> FILL. Abort from either state -> FILL.
- Abort:
  - Clears staging, lane_idx and elem_cnt. No beat emitted, vec_done not pulsed, vec_count unchanged.
  - If asserted together with an accepting handshake, abort wins and the pair is dropped.
  - A beat already registered on vec_valid this cycle completes. Downstream recovery of the partial vector is the system's responsibility.
- ACTIVE_LANES=1: every accepted pair is its own beat.
- ELEMS multiple of ACTIVE_LANES: no padding.
- Reset mid-vector: all state discarded and outputs forced to reset values immediately (async).

Decomposition:
- Shared package vmac_pkg holds:
  - BUSW=128 and BYTE_W=8;
  - LANE_MAX=16;
  - a constant function beats_per_vec(elems, lanes) = ceil division;
  - the FSM state enum {FILL, GAP}.
- One natural sub-module, lane_stager: byte-addressed staging register with write-enable, lane index and clear. The FSM and counters stay in the top.

Test Plan:
- ELEMS=1000, ACTIVE_LANES=8, all pairs (1,1) back-to-back -> 125 beats, each vec_a=vec_b=0x0000..00_0101010101010101; vec_done on beat 125; vec_count=1; MAC result_sum=1000.
- ELEMS=1000, ACTIVE_LANES=16, pairs (0xFF,0xFF) -> 63 beats; beat 63 has lanes 0-7 = 0xFF and lanes 8-15 = 0; MAC sum=65025000.
- ELEMS=1000, ACTIVE_LANES=1, two vectors streamed with in_valid held high -> 1000 beats each, in_ready=0 for exactly one cycle after element 999, at least one vec_valid=0 cycle between vectors, vec_count=2.
- ELEMS=1000, ACTIVE_LANES=8, random in_valid (50%) and random bytes, 100 vectors -> MAC results match golden sum per vector; vec_valid never high with bytes >= 8 nonzero.
- Abort at element 500 coincident with a handshake, then a full vector of (2,3) -> no vec_done for the aborted vector, vec_count=1, MAC sum=6000.
- rst_n pulsed low mid-vector (element 300) -> vec_valid/vec_a/vec_b/vec_count=0 while low; after release, a full vector of (1,1) yields vec_count=1, sum=1000.
